// File: rtl/regfile_sb_if.sv
// Issue-side bus of the register file / scoreboard block.
// The master side (decode + execute + writeback) drives instructions,
// writebacks, flush and out_ready. The slave side (regfile_sb) returns
// in_ready, the issued instruction and the scoreboard state.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NWB   = 2,
    parameter int OPW   = 5
) ();
    localparam int AW = $clog2(NREGS);

    logic                  flush;

    logic                  in_valid;
    logic                  in_ready;
    logic [AW-1:0]         in_rs1_sel;
    logic [AW-1:0]         in_rs2_sel;
    logic [AW-1:0]         in_rd_sel;
    logic                  in_rd_en;
    logic [31:0]           in_imm32;
    logic [OPW-1:0]        in_alu_op;

    logic [NWB-1:0]        wb_en;
    logic [NWB*AW-1:0]     wb_sel;
    logic [NWB*XLEN-1:0]   wb_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_rs1_value;
    logic [XLEN-1:0]       out_rs2_value;
    logic [AW-1:0]         out_wb_sel;
    logic                  out_wb_en;
    logic [31:0]           out_imm32;
    logic [OPW-1:0]        out_alu_op;

    logic [NREGS-1:0]      busy;

    modport master (
        output flush,
        output in_valid, in_rs1_sel, in_rs2_sel, in_rd_sel, in_rd_en, in_imm32, in_alu_op,
        input  in_ready,
        output wb_en, wb_sel, wb_data,
        output out_ready,
        input  out_valid, out_rs1_value, out_rs2_value, out_wb_sel, out_wb_en,
        input  out_imm32, out_alu_op,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid, in_rs1_sel, in_rs2_sel, in_rd_sel, in_rd_en, in_imm32, in_alu_op,
        output in_ready,
        input  wb_en, wb_sel, wb_data,
        input  out_ready,
        output out_valid, out_rs1_value, out_rs2_value, out_wb_sel, out_wb_en,
        output out_imm32, out_alu_op,
        output busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with integrated scoreboard and a one-entry registered
// valid/ready issue stage, placed between decode and execute.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle
// writeback data to the operand read and to let a register that is being
// written back this cycle stop counting as busy for hazard detection.
// Without it, operands always come from the array and a dependent
// instruction issues one cycle after its producer's writeback.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NWB      = 2,
    parameter int OPW      = 5,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        resetn,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    // Architectural state
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;

    // Writeback decode: per-register write strobe/data and busy-clear vector
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] clr_vec;

    // Issue-side decisions
    logic [NREGS-1:0] busy_eff;
    logic [NREGS-1:0] set_vec;
    logic             hazard;
    logic             accept;
    logic             rd_is_zero;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;

    // Output stage
    logic             out_valid_p1;
    logic [XLEN-1:0]  out_rs1_value_p1;
    logic [XLEN-1:0]  out_rs2_value_p1;
    logic [AW-1:0]    out_wb_sel_p1;
    logic             out_wb_en_p1;
    logic [31:0]      out_imm32_p1;
    logic [OPW-1:0]   out_alu_op_p1;

    // Decode writeback ports; later ports overwrite earlier ones so the
    // highest-indexed port wins a same-register collision.
    always_comb begin
        wr_hit  = '0;
        clr_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int i = 0; i < NWB; i++) begin
            if (bus.wb_en[i]) begin
                clr_vec[bus.wb_sel[i*AW +: AW]] = 1'b1;
                if (!(ZERO_REG != 0 && bus.wb_sel[i*AW +: AW] == '0)) begin
                    wr_hit[bus.wb_sel[i*AW +: AW]] = 1'b1;
                    wr_val[bus.wb_sel[i*AW +: AW]] = bus.wb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A register whose producer writes back this cycle no longer blocks.
    assign busy_eff = busy_q & ~clr_vec;
`else
    // Any outstanding producer blocks until its data has landed in the array.
    assign busy_eff = busy_q;
`endif

    assign hazard = busy_eff[bus.in_rs1_sel]
                  | busy_eff[bus.in_rs2_sel]
                  | (bus.in_rd_en & busy_eff[bus.in_rd_sel]);

    assign bus.in_ready = !bus.flush && !hazard && (!out_valid_p1 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign rd_is_zero   = (ZERO_REG != 0) && (bus.in_rd_sel == '0);

    // Operand read: array contents, optionally overridden by same-cycle
    // writeback data, and forced to zero for the hardwired zero register.
    always_comb begin
        rs1_val = regs[bus.in_rs1_sel];
        rs2_val = regs[bus.in_rs2_sel];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit[bus.in_rs1_sel]) begin
            rs1_val = wr_val[bus.in_rs1_sel];
        end
        if (wr_hit[bus.in_rs2_sel]) begin
            rs2_val = wr_val[bus.in_rs2_sel];
        end
`endif
        if (ZERO_REG != 0 && bus.in_rs1_sel == '0) begin
            rs1_val = '0;
        end
        if (ZERO_REG != 0 && bus.in_rs2_sel == '0) begin
            rs2_val = '0;
        end
    end

    // New producer marked busy on accept (never for the zero register).
    always_comb begin
        set_vec = '0;
        if (accept && bus.in_rd_en && !rd_is_zero) begin
            set_vec[bus.in_rd_sel] = 1'b1;
        end
    end

    // Register array update; writebacks land even during a flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Scoreboard: clears from writebacks, set from accept (set wins).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else if (bus.flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    // Issue stage: load on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_p1     <= 1'b0;
            out_rs1_value_p1 <= '0;
            out_rs2_value_p1 <= '0;
            out_wb_sel_p1    <= '0;
            out_wb_en_p1     <= 1'b0;
            out_imm32_p1     <= '0;
            out_alu_op_p1    <= '0;
        end else if (bus.flush) begin
            out_valid_p1     <= 1'b0;
        end else if (accept) begin
            out_valid_p1     <= 1'b1;
            out_rs1_value_p1 <= rs1_val;
            out_rs2_value_p1 <= rs2_val;
            out_wb_sel_p1    <= bus.in_rd_sel;
            out_wb_en_p1     <= bus.in_rd_en;
            out_imm32_p1     <= bus.in_imm32;
            out_alu_op_p1    <= bus.in_alu_op;
        end else if (bus.out_ready) begin
            out_valid_p1     <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_p1;
    assign bus.out_rs1_value = out_rs1_value_p1;
    assign bus.out_rs2_value = out_rs2_value_p1;
    assign bus.out_wb_sel    = out_wb_sel_p1;
    assign bus.out_wb_en     = out_wb_en_p1;
    assign bus.out_imm32     = out_imm32_p1;
    assign bus.out_alu_op    = out_alu_op_p1;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the register file, the busy
// set and the one-entry issue slot.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NWB   = 2;
    localparam int OPW   = 5;
    localparam int AW    = $clog2(NREGS);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NWB(NWB), .OPW(OPW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NWB(NWB), .OPW(OPW), .ZERO_REG(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference model state
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_ov;
    logic [XLEN-1:0]  m_rs1;
    logic [XLEN-1:0]  m_rs2;
    logic [AW-1:0]    m_wsel;
    logic             m_wen;
    logic [31:0]      m_imm;
    logic [OPW-1:0]   m_op;

    int n_tests = 0;
    int n_fail  = 0;
    logic last_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_busy = '0;
        m_ov   = 1'b0;
        m_rs1  = '0;
        m_rs2  = '0;
        m_wsel = '0;
        m_wen  = 1'b0;
        m_imm  = '0;
        m_op   = '0;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_rs1_sel = '0;
        bus.in_rs2_sel = '0;
        bus.in_rd_sel  = '0;
        bus.in_rd_en   = 1'b0;
        bus.in_imm32   = '0;
        bus.in_alu_op  = '0;
        bus.wb_en      = '0;
        bus.wb_sel     = '0;
        bus.wb_data    = '0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input bit rd_en,
                         input logic [31:0] imm, input int op);
        bus.in_valid   = 1'b1;
        bus.in_rs1_sel = AW'(rs1);
        bus.in_rs2_sel = AW'(rs2);
        bus.in_rd_sel  = AW'(rd);
        bus.in_rd_en   = rd_en;
        bus.in_imm32   = imm;
        bus.in_alu_op  = OPW'(op);
    endtask

    task automatic wb(input int port, input int sel, input logic [XLEN-1:0] data);
        bus.wb_en[port]              = 1'b1;
        bus.wb_sel[port*AW +: AW]    = AW'(sel);
        bus.wb_data[port*XLEN +: XLEN] = data;
    endtask

    // One clock cycle: predict from current inputs, check in_ready before the
    // edge, advance the model, check all outputs after the edge.
    task automatic step();
        logic [XLEN-1:0]  nxt [NREGS];
        logic [NREGS-1:0] wr;
        logic             haz, rdy, acc;
        logic [XLEN-1:0]  a, b;
        int s, r1, r2, rd;
        wr = '0;
        for (int r = 0; r < NREGS; r++) nxt[r] = m_mem[r];
        for (int i = 0; i < NWB; i++) begin
            if (bus.wb_en[i]) begin
                s = int'(bus.wb_sel[i*AW +: AW]);
                wr[s] = 1'b1;
                if (s != 0) nxt[s] = bus.wb_data[i*XLEN +: XLEN];
            end
        end
        r1 = int'(bus.in_rs1_sel);
        r2 = int'(bus.in_rs2_sel);
        rd = int'(bus.in_rd_sel);
        haz = (m_busy[r1] && !(BYP && wr[r1]))
           || (m_busy[r2] && !(BYP && wr[r2]))
           || (bus.in_rd_en && m_busy[rd] && !(BYP && wr[rd]));
        rdy = !bus.flush && !haz && (!m_ov || bus.out_ready);
        acc = bus.in_valid && rdy;
        a = (r1 == 0) ? '0 : ((BYP && wr[r1]) ? nxt[r1] : m_mem[r1]);
        b = (r2 == 0) ? '0 : ((BYP && wr[r2]) ? nxt[r2] : m_mem[r2]);
        #1;
        last_ready = bus.in_ready;
        chk("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        #1;
        for (int r = 0; r < NREGS; r++) m_mem[r] = nxt[r];
        if (bus.flush) begin
            m_busy = '0;
            m_ov   = 1'b0;
        end else begin
            m_busy = m_busy & ~wr;
            if (acc && bus.in_rd_en && rd != 0) m_busy[rd] = 1'b1;
            if (acc) begin
                m_ov   = 1'b1;
                m_rs1  = a;
                m_rs2  = b;
                m_wsel = bus.in_rd_sel;
                m_wen  = bus.in_rd_en;
                m_imm  = bus.in_imm32;
                m_op   = bus.in_alu_op;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
        chk("out_valid", bus.out_valid, m_ov);
        chk("busy", bus.busy, m_busy);
        chk("out_rs1_value", bus.out_rs1_value, m_rs1);
        chk("out_rs2_value", bus.out_rs2_value, m_rs2);
        chk("out_wb_sel", bus.out_wb_sel, m_wsel);
        chk("out_wb_en", bus.out_wb_en, m_wen);
        chk("out_imm32", bus.out_imm32, m_imm);
        chk("out_alu_op", bus.out_alu_op, m_op);
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, '0);
        chk("rst_out_rs1", bus.out_rs1_value, '0);
        chk("rst_out_imm", bus.out_imm32, '0);
        resetn = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Read after reset
        issue(3, 4, 0, 1'b0, 32'h0, 0);
        step();
        chk("rd0_valid", bus.out_valid, 1'b1);
        chk("rd0_rs1", bus.out_rs1_value, 32'h0);
        chk("rd0_rs2", bus.out_rs2_value, 32'h0);
        chk("rd0_busy", bus.busy, '0);

        // Write then read
        idle();
        wb(0, 5, 32'hDEADBEEF);
        step();
        idle();
        issue(5, 0, 0, 1'b0, 32'h11, 1);
        step();
        chk("wr_rd_x5", bus.out_rs1_value, 32'hDEADBEEF);

        // Zero register
        idle();
        wb(0, 0, 32'h1234);
        step();
        idle();
        issue(0, 0, 0, 1'b1, 32'h22, 2);
        step();
        chk("zero_rs1", bus.out_rs1_value, 32'h0);
        chk("zero_busy0", bus.busy[0], 1'b0);

        // RAW stall on x7
        idle();
        issue(1, 2, 7, 1'b1, 32'h33, 3);
        step();
        chk("raw_busy7", bus.busy[7], 1'b1);
        idle();
        issue(7, 0, 0, 1'b0, 32'h44, 4);
        step();
        chk("raw_stall", last_ready, 1'b0);
        wb(0, 7, 32'h55);
`ifdef REGFILE_BYPASS_EN
        step();
        chk("raw_bypass_accept", last_ready, 1'b1);
        chk("raw_bypass_val", bus.out_rs1_value, 32'h55);
`else
        step();
        chk("raw_wb_cycle_stall", last_ready, 1'b0);
        bus.wb_en = '0;
        step();
        chk("raw_accept", last_ready, 1'b1);
        chk("raw_val", bus.out_rs1_value, 32'h55);
`endif

        // Port collision: port 1 wins
        idle();
        wb(0, 9, 32'h1);
        wb(1, 9, 32'h2);
        step();
        idle();
        issue(9, 0, 0, 1'b0, 32'h0, 0);
        step();
        chk("collision_x9", bus.out_rs1_value, 32'h2);

        // Backpressure then flush
        idle();
        issue(5, 0, 11, 1'b1, 32'hA5A5, 3);
        step();
        issue(6, 0, 0, 1'b0, 32'h5A5A, 6);
        bus.out_ready = 1'b0;
        step();
        chk("bp_ready", last_ready, 1'b0);
        step();
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        chk("bp_hold_imm", bus.out_imm32, 32'hA5A5);
        chk("bp_hold_rs1", bus.out_rs1_value, 32'hDEADBEEF);
        chk("bp_busy11", bus.busy[11], 1'b1);
        bus.flush = 1'b1;
        step();
        chk("flush_ready", last_ready, 1'b0);
        chk("flush_busy", bus.busy, '0);
        chk("flush_valid", bus.out_valid, 1'b0);

        // Randomized traffic on a small register window to provoke hazards
        for (int k = 0; k < 2000; k++) begin
            idle();
            bus.in_valid   = ($urandom_range(0, 9) < 8);
            bus.in_rs1_sel = AW'($urandom_range(0, 7));
            bus.in_rs2_sel = AW'($urandom_range(0, 7));
            bus.in_rd_sel  = AW'($urandom_range(0, 7));
            bus.in_rd_en   = 1'($urandom_range(0, 1));
            bus.in_imm32   = $urandom;
            bus.in_alu_op  = OPW'($urandom);
            for (int i = 0; i < NWB; i++) begin
                if ($urandom_range(0, 2) == 0) wb(i, $urandom_range(0, 7), $urandom);
            end
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset in the middle of activity
        idle();
        issue(1, 2, 3, 1'b1, 32'h77, 7);
        wb(0, 4, 32'hCAFE);
        step();
        resetn = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_busy", bus.busy, '0);
        chk("arst_rs1", bus.out_rs1_value, '0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        idle();
        issue(4, 4, 0, 1'b0, 32'h0, 0);
        step();
        chk("arst_x4_cleared", bus.out_rs1_value, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated scoreboard and a registered valid/ready issue stage. It sits between decode and execute. It accepts one decoded instruction per cycle, stalls on RAW and WAW hazards against in-flight destinations, and absorbs up to NWB writebacks per cycle. It presents operands plus the pass-through fields to execute one cycle after acceptance.

## Interface
- XLEN, 32, register and data width
- NREGS, 32, number of architectural registers; power of two, at least 2; AW = $clog2(NREGS)
- NWB, 2, number of writeback ports
- OPW, 5, alu_op width
- ZERO_REG, 1, when 1 register 0 reads as zero, is never written, and is never busy
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  decode has an instruction
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_rs1_sel, in_rs2_sel, in_rd_sel  in  AW each  source and destination selects
- in_rd_en  in  1  instruction writes rd
- in_imm32  in  32  immediate, passed through
- in_alu_op  in  OPW  op code, passed through
- wb_en  in  NWB  per-port write enable
- wb_sel  in  NWB*AW  per-port destination, port i at [i*AW +: AW]
- wb_data  in  NWB*XLEN  per-port data
- out_valid  out  1  issue stage holds an instruction
- out_ready  in  1  execute consumes when out_valid && out_ready
- out_rs1_value, out_rs2_value  out  XLEN each  operands
- out_wb_sel  out  AW  destination
- out_wb_en  out  1  registered in_rd_en
- out_imm32  out  32  registered immediate
- out_alu_op  out  OPW  registered op code
- busy  out  NREGS  scoreboard state, for debug and verification

## Operation
- Storage: NREGS x XLEN flops, all cleared on reset.
- Write: each port i with wb_en[i] writes wb_data[i] to wb_sel[i]. Writes to register 0 are dropped when ZERO_REG=1.
- Same-cycle collision on one register: the highest-indexed port wins.
- Scoreboard set: busy[rd] is set on accept when in_rd_en and rd is not a zero register.
- Scoreboard clear: busy[r] is cleared by any wb_en[i] with wb_sel[i]==r.
- Set and clear of the same register in one cycle: set wins, because the newly accepted instruction is the new producer.
- Hazard is the OR of:
  - busy[rs1] and the register is not being written this cycle
  - busy[rs2] and the register is not being written this cycle
  - in_rd_en and busy[rd] (WAW), with the same qualifier
- Without REGFILE_BYPASS_EN, the "not being written this cycle" qualifier is absent: any busy source or destination stalls.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Operand read:
  - register 0 returns 0 when ZERO_REG=1
  - otherwise the current writeback value if bypass applies, else array contents
- Operands are captured into the output stage on accept.
- Output stage:
  - on accept, load all out_* fields and set out_valid
  - else if out_ready, clear out_valid
  - else hold all fields stable
- Flush:
  - clears all busy bits and out_valid at the next edge
  - blocks acceptance in the flush cycle
  - writebacks in the flush cycle still update the array

## Timing
- Reset values:
  - out_valid=0 and busy=0
  - all out_* data fields are 0
  - in_ready=1 once resetn is deasserted and flush is low
- Accept at edge t gives out_valid=1 in cycle t+1; issue latency is 1 cycle.
- Writeback asserted in cycle w:
  - data is visible in the array from w+1
  - with bypass, a dependent instruction can be accepted in cycle w
  - without bypass, the earliest acceptance is w+1
- Back-to-back issue at full rate is sustained when there are no hazards and out_ready=1.
- Reset asserted mid-operation drops any in-flight instruction and all busy state immediately (asynchronous).

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle writeback-to-read forwarding is enabled, and hazard checks ignore registers being cleared this cycle.
- REGFILE_BYPASS_EN undefined: there is no forwarding mux; operands always come from the array, and a dependent instruction issues one cycle later.

## Test plan
- Reset then read: with all registers zero, accept rs1=3, rs2=4 → next cycle out_valid=1, both operands 0, busy=0.
- Write and read: wb port0 writes x5=0xDEADBEEF; the next cycle, issue rs1=5 → out_rs1_value=0xDEADBEEF.
- Zero register: write x0=0x1234, then issue rs1=0 → operand 0 and busy[0]=0.
- RAW stall: accept rd=7 at cycle 0, then present rs1=7 at cycle 1 → in_ready=0 until wb x7=0x55.
  - bypass build: accept in the wb cycle, with operand 0x55
  - no-bypass build: accept one cycle later
- Port collision: ports 0 and 1 both write x9 with 0x1 and 0x2 → x9=0x2.
- Backpressure and flush:
  - hold out_ready=0 → out_* stable and in_ready=0
  - assert flush → busy=0 and out_valid=0 next cycle
